// File: rtl/chunked_pattern_det_pkg.sv
// Shared types and helpers for the chunked reduction detector:
// predicate modes, FSM states, per-mode default result and padding value.
package chunked_det_pkg;

  typedef enum logic [1:0] {
    ALL_ONES  = 2'd0,
    ALL_ZEROS = 2'd1,
    ANY_ONE   = 2'd2,
    ANY_ZERO  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  // Result reported when no chunk decides.
  function automatic logic default_z(input mode_e m);
    case (m)
      ALL_ONES, ALL_ZEROS: default_z = 1'b1;
      ANY_ONE, ANY_ZERO:   default_z = 1'b0;
      default:             default_z = 1'b0;
    endcase
  endfunction

  // Fill value above the operand MSB; always the non-deciding polarity.
  function automatic logic pad_bit(input mode_e m);
    case (m)
      ALL_ONES, ANY_ZERO: pad_bit = 1'b1;
      ALL_ZEROS, ANY_ONE: pad_bit = 1'b0;
      default:            pad_bit = 1'b0;
    endcase
  endfunction

  function automatic int calc_idx_w(input int n);
    calc_idx_w = (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chunked_pattern_det_if.sv
// Operand/result handshake bundle of the chunked reduction detector.
interface chunked_pattern_det_if
  import chunked_det_pkg::*;
#(
  parameter int width = 64,
  parameter int idxW  = 3
) ();

  logic             InValid;
  logic             InReady;
  logic [width-1:0] A;
  mode_e            Mode;
  logic             OutValid;
  logic             OutReady;
  logic             Z;
  logic             DecFound;
  logic [idxW-1:0]  DecIdx;

  modport master (
    output InValid, A, Mode, OutReady,
    input  InReady, OutValid, Z, DecFound, DecIdx
  );

  modport slave (
    input  InValid, A, Mode, OutReady,
    output InReady, OutValid, Z, DecFound, DecIdx
  );

endinterface

// File: rtl/chunked_pattern_det_chunk_eval.sv
// Decides whether one padded chunk flips the predicate away from its default,
// using an AND reduction of the slice or of its inverse.
module chunk_eval
  import chunked_det_pkg::*;
#(
  parameter int chunkWidth = 8
) (
  input  logic [chunkWidth-1:0] i_slice,
  input  mode_e                 i_mode,
  output logic                  o_decided
);

  // A chunk decides when it is not uniformly the default-preserving value.
  always_comb begin
    o_decided = 1'b0;
    case (i_mode)
      ALL_ONES, ANY_ZERO: o_decided = ~(&i_slice);
      ALL_ZEROS, ANY_ONE: o_decided = ~(&(~i_slice));
      default:            o_decided = 1'b0;
    endcase
  end

endmodule

// File: rtl/chunked_pattern_det.sv
// Multi-cycle reduction detector: scans a wide operand chunkWidth bits per
// cycle and reports the selected predicate plus the first deciding chunk.
module chunked_pattern_det
  import chunked_det_pkg::*;
#(
  parameter int width      = 64,
  parameter int chunkWidth = 8,
  parameter bit EarlyExit  = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  chunked_pattern_det_if.slave bus
);

  localparam int numChunks = (width + chunkWidth - 1) / chunkWidth;
  localparam int idxW      = calc_idx_w(numChunks);
  localparam int PadW      = numChunks * chunkWidth;
  localparam logic [idxW-1:0] LastIdx = idxW'(numChunks - 1);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [width-1:0]      r_op;
  mode_e                 r_mode;
  logic [idxW-1:0]       r_cnt;
  logic [chunkWidth-1:0] r_slice;
  logic [idxW-1:0]       r_slice_idx;
  logic                  r_slice_vld;
  logic                  r_z;
  logic                  r_found;
  logic [idxW-1:0]       r_idx;

  logic [PadW-1:0]       w_padded;
  logic [chunkWidth-1:0] w_fetch;
  logic                  w_dec;
  logic                  w_accept;
  logic                  w_eval_last;
  logic                  w_first_dec;

  // The chunk select is registered before evaluation so the wide mux and the
  // reduction land in separate cycles; this costs one cycle of latency.
  always_comb begin
    w_padded              = {PadW{pad_bit(r_mode)}};
    w_padded[width-1:0]   = r_op;
    w_fetch               = w_padded[int'(r_cnt) * chunkWidth +: chunkWidth];
  end

  chunk_eval #(
    .chunkWidth (chunkWidth)
  ) u_eval (
    .i_slice   (r_slice),
    .i_mode    (r_mode),
    .o_decided (w_dec)
  );

  assign w_accept    = bus.InValid && (r_state == IDLE);
  assign w_eval_last = r_slice_vld && (r_slice_idx == LastIdx);
  assign w_first_dec = r_slice_vld && w_dec && !r_found;

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = SCAN;
        else          w_state_nxt = IDLE;
      end
      SCAN: begin
        if (r_slice_vld && ((w_dec && EarlyExit) || w_eval_last)) w_state_nxt = DONE;
        else                                                      w_state_nxt = SCAN;
      end
      DONE: begin
        if (bus.OutReady) w_state_nxt = IDLE;
        else              w_state_nxt = DONE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // Operand capture, chunk fetch and result recording.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_op        <= '0;
      r_mode      <= ALL_ONES;
      r_cnt       <= '0;
      r_slice     <= '0;
      r_slice_idx <= '0;
      r_slice_vld <= 1'b0;
      r_z         <= 1'b0;
      r_found     <= 1'b0;
      r_idx       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op        <= bus.A;
            r_mode      <= bus.Mode;
            r_cnt       <= '0;
            r_slice_vld <= 1'b0;
            r_z         <= 1'b0;
            r_found     <= 1'b0;
            r_idx       <= '0;
          end
        end
        SCAN: begin
          r_slice     <= w_fetch;
          r_slice_idx <= r_cnt;
          r_slice_vld <= 1'b1;
          if (r_cnt != LastIdx) r_cnt <= r_cnt + idxW'(1);
          // Only the first deciding chunk is recorded.
          if (w_first_dec) begin
            r_z     <= ~default_z(r_mode);
            r_found <= 1'b1;
            r_idx   <= r_slice_idx;
          end else if (w_eval_last && !r_found) begin
            r_z   <= default_z(r_mode);
            r_idx <= LastIdx;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.InReady  = (r_state == IDLE);
  assign bus.OutValid = (r_state == DONE);
  assign bus.Z        = r_z;
  assign bus.DecFound = r_found;
  assign bus.DecIdx   = r_idx;

endmodule

// File: tb/tb_chunked_pattern_det.sv
// Scoreboard bench: two 20-bit/8-bit instances (early exit on and off) plus a
// single-chunk 8-bit instance; a monitor pops expected results on OutValid.
module tb_chunked_pattern_det;
  import chunked_det_pkg::*;

  typedef struct {
    logic       z;
    logic       found;
    logic [1:0] idx;
    int         lat;
    int         acc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_fail;

  logic        in_valid;
  logic [19:0] a_val;
  mode_e       mode_val;
  logic        out_ready;
  logic        c_valid;
  logic [7:0]  c_a;
  mode_e       c_mode;

  chunked_pattern_det_if #(.width(20), .idxW(2)) if_a ();
  chunked_pattern_det_if #(.width(20), .idxW(2)) if_b ();
  chunked_pattern_det_if #(.width(8),  .idxW(1)) if_c ();

  assign if_a.InValid  = in_valid;
  assign if_a.A        = a_val;
  assign if_a.Mode     = mode_val;
  assign if_a.OutReady = out_ready;
  assign if_b.InValid  = in_valid;
  assign if_b.A        = a_val;
  assign if_b.Mode     = mode_val;
  assign if_b.OutReady = out_ready;
  assign if_c.InValid  = c_valid;
  assign if_c.A        = c_a;
  assign if_c.Mode     = c_mode;
  assign if_c.OutReady = 1'b1;

  chunked_pattern_det #(.width(20), .chunkWidth(8), .EarlyExit(1'b1)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .bus(if_a));
  chunked_pattern_det #(.width(20), .chunkWidth(8), .EarlyExit(1'b0)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .bus(if_b));
  chunked_pattern_det #(.width(8), .chunkWidth(8), .EarlyExit(1'b1)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .bus(if_c));

  logic [2:0] ov;
  logic [2:0] zv;
  logic [2:0] fv;
  logic [1:0] idxv [3];
  assign ov      = {if_c.OutValid, if_b.OutValid, if_a.OutValid};
  assign zv      = {if_c.Z, if_b.Z, if_a.Z};
  assign fv      = {if_c.DecFound, if_b.DecFound, if_a.DecFound};
  assign idxv[0] = if_a.DecIdx;
  assign idxv[1] = if_b.DecIdx;
  assign idxv[2] = {1'b0, if_c.DecIdx};

  exp_t q [3][$];
  exp_t cur [3];
  logic prev [3];
  logic has_cur [3];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
  endtask

  function automatic exp_t mk(input logic z, input logic f, input logic [1:0] idx,
                              input int lat, input int acc);
    exp_t e;
    e.z = z; e.found = f; e.idx = idx; e.lat = lat; e.acc = acc;
    return e;
  endfunction

  // Monitor: pops on the first OutValid cycle, then checks hold-stability.
  initial begin
    for (int d = 0; d < 3; d++) begin
      prev[d] = 1'b0;
      has_cur[d] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (!rst_n) begin
          prev[d] = 1'b0;
        end else begin
          if (ov[d]) begin
            if (!prev[d]) begin
              if (q[d].size() == 0) begin
                n_checks++;
                n_fail++;
                has_cur[d] = 1'b0;
                $display("FAIL unexpected_result dut%0d: got OutValid=1 expected no result", d);
              end else begin
                cur[d] = q[d].pop_front();
                has_cur[d] = 1'b1;
                check($sformatf("latency_dut%0d", d), cyc - cur[d].acc, cur[d].lat);
              end
            end
            if (has_cur[d]) begin
              check($sformatf("Z_dut%0d", d), zv[d], cur[d].z);
              check($sformatf("DecFound_dut%0d", d), fv[d], cur[d].found);
              check($sformatf("DecIdx_dut%0d", d), idxv[d], cur[d].idx);
            end
          end
          prev[d] = ov[d];
        end
      end
    end
  end

  task automatic wait_ready_ab();
    int t = 0;
    while (!(if_a.InReady && if_b.InReady) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) timeout_fail("wait_ready_ab");
  endtask

  task automatic issue_ab(input logic [19:0] a, input mode_e m, input logic z, input logic f,
                          input logic [1:0] idx, input int lat_a, input int lat_b, input bit push);
    wait_ready_ab();
    a_val = a;
    mode_val = m;
    in_valid = 1'b1;
    if (push) begin
      q[0].push_back(mk(z, f, idx, lat_a, cyc + 1));
      q[1].push_back(mk(z, f, idx, lat_b, cyc + 1));
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic issue_c(input logic [7:0] a, input mode_e m, input logic z, input logic f);
    int t = 0;
    while (!if_c.InReady && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) timeout_fail("wait_ready_c");
    c_a = a;
    c_mode = m;
    c_valid = 1'b1;
    q[2].push_back(mk(z, f, 2'd0, 2, cyc + 1));
    @(negedge clk);
    c_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    cyc = 0;
    n_checks = 0;
    n_fail = 0;
    in_valid = 1'b0;
    a_val = 20'h00000;
    mode_val = ALL_ONES;
    out_ready = 1'b1;
    c_valid = 1'b0;
    c_a = 8'h00;
    c_mode = ALL_ONES;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    check("reset_InReady", if_a.InReady, 1'b1);
    check("reset_OutValid", if_a.OutValid, 1'b0);
    check("reset_Z", if_a.Z, 1'b0);
    check("reset_DecFound", if_a.DecFound, 1'b0);
    check("reset_DecIdx", if_a.DecIdx, 2'd0);
    rst_n = 1'b1;
    @(negedge clk);

    //        A         mode       Z     Found idx  latA latB
    issue_ab(20'hFFFFF, ALL_ONES,  1'b1, 1'b0, 2'd2, 4, 4, 1'b1);
    issue_ab(20'hFFEFF, ALL_ONES,  1'b0, 1'b1, 2'd1, 3, 4, 1'b1);
    issue_ab(20'h00000, ALL_ZEROS, 1'b1, 1'b0, 2'd2, 4, 4, 1'b1);
    issue_ab(20'h80000, ALL_ZEROS, 1'b0, 1'b1, 2'd2, 4, 4, 1'b1);
    issue_ab(20'h00000, ANY_ONE,   1'b0, 1'b0, 2'd2, 4, 4, 1'b1);
    issue_ab(20'hFFFFF, ANY_ZERO,  1'b0, 1'b0, 2'd2, 4, 4, 1'b1);
    issue_ab(20'h00100, ANY_ONE,   1'b1, 1'b1, 2'd1, 3, 4, 1'b1);
    issue_ab(20'h00000, ALL_ONES,  1'b0, 1'b1, 2'd0, 2, 4, 1'b1);
    issue_ab(20'hFFF0F, ANY_ZERO,  1'b1, 1'b1, 2'd0, 2, 4, 1'b1);

    // Backpressure: result held while a new operand waits at the input.
    wait_ready_ab();
    out_ready = 1'b0;
    issue_ab(20'h12345, ALL_ZEROS, 1'b0, 1'b1, 2'd0, 2, 4, 1'b1);
    t = 0;
    while (!(if_a.OutValid && if_b.OutValid) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) timeout_fail("wait_done_backpressure");
    a_val = 20'hFFFFF;
    mode_val = ALL_ONES;
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_InReady_a", if_a.InReady, 1'b0);
      check("bp_InReady_b", if_b.InReady, 1'b0);
    end
    out_ready = 1'b1;
    q[0].push_back(mk(1'b1, 1'b0, 2'd2, 4, cyc + 2));
    q[1].push_back(mk(1'b1, 1'b0, 2'd2, 4, cyc + 2));
    @(negedge clk);
    check("bp_idle_InReady_a", if_a.InReady, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_accepted_InReady_a", if_a.InReady, 1'b0);

    // Reset while chunk 1 is being evaluated.
    issue_ab(20'hFFFFF, ALL_ONES, 1'b1, 1'b0, 2'd2, 4, 4, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_OutValid_a", if_a.OutValid, 1'b0);
    check("rst_InReady_a", if_a.InReady, 1'b1);
    check("rst_OutValid_b", if_b.OutValid, 1'b0);
    check("rst_InReady_b", if_b.InReady, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue_ab(20'hFFFFF, ALL_ONES, 1'b1, 1'b0, 2'd2, 4, 4, 1'b1);

    // Single-chunk instance.
    issue_c(8'hFF, ALL_ONES,  1'b1, 1'b0);
    issue_c(8'h7F, ALL_ONES,  1'b0, 1'b1);
    issue_c(8'h00, ALL_ZEROS, 1'b1, 1'b0);

    t = 0;
    while ((q[0].size() + q[1].size() + q[2].size()) != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    check("drain_q_a", q[0].size(), 0);
    check("drain_q_b", q[1].size(), 0);
    check("drain_q_c", q[2].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
